// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer
//   Generation controller for a LifeCell array. Drives the array-wide synchronous
//   cell reset and seed-source select, mirrors the cells' 8-phase evaluation
//   cycle, flags each completed generation and counts generations. Accepts
//   start / pause / step / resume / stop commands so the grid can be frozen at
//   a generation boundary and restarted without losing its pattern.
//
// Parameters
//   GEN_W     width of the generation counter
//   MAX_GENS  automatic pause after this many generations (0 = unlimited)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      pulse: load external pattern and run (IDLE only)
//   pause      pulse: freeze at next generation boundary (RUN only)
//   step       pulse: run one generation then freeze (HOLD only)
//   resume     pulse: continue free-running (HOLD only)
//   stop       pulse: abort to IDLE (any state)
//   cell_nrst  active-low synchronous reset to every cell (high in RUN)
//   seed_sel   seed mux select: 0 = external pattern, 1 = cell's own alive
//   phase      mirror of the cell FSM state, 0 outside RUN
//   gen_done   one-cycle pulse, alive outputs hold the new generation
//   gen_count  completed generations since last start (saturating)
//   running    state is RUN
//   holding    state is HOLD
//   limit_hit  sticky, MAX_GENS reached; cleared by start or stop
module life_gen_sequencer #(
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned MAX_GENS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             resume,
  input  logic             stop,
  output logic             cell_nrst,
  output logic             seed_sel,
  output logic [2:0]       phase,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  output logic             running,
  output logic             holding,
  output logic             limit_hit
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  localparam bit               LimitEn  = (MAX_GENS != 0);
  localparam logic [GEN_W-1:0] MaxGensW = GEN_W'(MAX_GENS);
  localparam logic [2:0]       PhLast   = 3'd7;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             seed_sel_q, seed_sel_d;
  logic             gen_done_q, gen_done_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             limit_hit_q, limit_hit_d;
  logic             pause_pend_q, pause_pend_d;
  logic             step_pend_q, step_pend_d;

  logic [GEN_W-1:0] gen_inc;
  logic             limit_reached;
  logic             boundary_exit;

  // Saturating increment used at every generation boundary.
  assign gen_inc       = (gen_count_q == {GEN_W{1'b1}}) ? gen_count_q
                                                        : gen_count_q + GEN_W'(1);
  assign limit_reached = LimitEn && (gen_inc == MaxGensW);
  // A pause arriving in the phase-7 cycle itself still freezes at this boundary.
  assign boundary_exit = pause_pend_q | step_pend_q | pause | limit_reached;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    seed_sel_d   = seed_sel_q;
    gen_done_d   = 1'b0;
    gen_count_d  = gen_count_q;
    limit_hit_d  = limit_hit_q;
    pause_pend_d = pause_pend_q;
    step_pend_d  = step_pend_q;

    if (stop) begin
      // Abort: cells keep the last completed generation since alive is only
      // written in phases 0 and 7; no gen_done, count held.
      state_d      = StIdle;
      phase_d      = 3'd0;
      seed_sel_d   = 1'b0;
      limit_hit_d  = 1'b0;
      pause_pend_d = 1'b0;
      step_pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d      = StRun;
            phase_d      = 3'd0;
            seed_sel_d   = 1'b0;
            gen_count_d  = '0;
            limit_hit_d  = 1'b0;
            pause_pend_d = 1'b0;
            step_pend_d  = 1'b0;
          end
        end

        StRun: begin
          if (phase_q == PhLast) begin
            gen_done_d  = 1'b1;
            gen_count_d = gen_inc;
            if (limit_reached) begin
              limit_hit_d = 1'b1;
            end
            if (boundary_exit) begin
              state_d      = StHold;
              phase_d      = 3'd0;
              seed_sel_d   = 1'b1;  // re-entry reloads the frozen pattern
              pause_pend_d = 1'b0;
              step_pend_d  = 1'b0;
            end else begin
              phase_d = 3'd1;       // phase 0 only occurs on entry
            end
          end else begin
            phase_d = phase_q + 3'd1;
            if (pause) begin
              pause_pend_d = 1'b1;
            end
          end
        end

        StHold: begin
          if (step || resume) begin
            state_d     = StRun;
            phase_d     = 3'd0;
            seed_sel_d  = 1'b1;
            // Once the limit is reached, resume only advances one generation.
            step_pend_d = step | limit_hit_q;
          end
        end

        default: begin
          state_d = StIdle;
          phase_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= 3'd0;
      seed_sel_q   <= 1'b0;
      gen_done_q   <= 1'b0;
      gen_count_q  <= '0;
      limit_hit_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      step_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      seed_sel_q   <= seed_sel_d;
      gen_done_q   <= gen_done_d;
      gen_count_q  <= gen_count_d;
      limit_hit_q  <= limit_hit_d;
      pause_pend_q <= pause_pend_d;
      step_pend_q  <= step_pend_d;
    end
  end

  assign cell_nrst = (state_q == StRun);
  assign running   = (state_q == StRun);
  assign holding   = (state_q == StHold);
  assign seed_sel  = seed_sel_q;
  assign phase     = phase_q;
  assign gen_done  = gen_done_q;
  assign gen_count = gen_count_q;
  assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
module tb_life_gen_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pause, step, resume, stop;
  logic        cell_nrst, seed_sel, gen_done, running, holding, limit_hit;
  logic [2:0]  phase;
  logic [15:0] gen_count;

  logic        start_l, resume_l, stop_l;
  logic        cell_nrst_l, seed_sel_l, gen_done_l, running_l, holding_l, limit_hit_l;
  logic [2:0]  phase_l;
  logic [15:0] gen_count_l;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned entry;

  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
    bit          hold;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  life_gen_sequencer #(.GEN_W(16), .MAX_GENS(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .step      (step),
    .resume    (resume),
    .stop      (stop),
    .cell_nrst (cell_nrst),
    .seed_sel  (seed_sel),
    .phase     (phase),
    .gen_done  (gen_done),
    .gen_count (gen_count),
    .running   (running),
    .holding   (holding),
    .limit_hit (limit_hit)
  );

  life_gen_sequencer #(.GEN_W(16), .MAX_GENS(4)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .start     (start_l),
    .pause     (1'b0),
    .step      (1'b0),
    .resume    (resume_l),
    .stop      (stop_l),
    .cell_nrst (cell_nrst_l),
    .seed_sel  (seed_sel_l),
    .phase     (phase_l),
    .gen_done  (gen_done_l),
    .gen_count (gen_count_l),
    .running   (running_l),
    .holding   (holding_l),
    .limit_hit (limit_hit_l)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitors: pop one expected generation per gen_done pulse.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && gen_done) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL gen_done_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("gen_done_cycle", cyc, e.cyc);
        chk("gen_count_at_done", gen_count, e.cnt);
        chk("holding_at_done", holding, e.hold);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && gen_done_l) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL lim_gen_done_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("lim_gen_done_cycle", cyc, e.cyc);
        chk("lim_gen_count_at_done", gen_count_l, e.cnt);
        chk("lim_holding_at_done", holding_l, e.hold);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    {start, pause, step, resume, stop} = '0;
    {start_l, resume_l, stop_l} = '0;
    repeat (3) @(negedge clk);

    chk("rst_cell_nrst", cell_nrst, 0);
    chk("rst_seed_sel", seed_sel, 0);
    chk("rst_phase", phase, 0);
    chk("rst_gen_done", gen_done, 0);
    chk("rst_gen_count", gen_count, 0);
    chk("rst_running", running, 0);
    chk("rst_holding", holding, 0);
    chk("rst_limit_hit", limit_hit, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start, phase sequence, pause in phase 3 of generation 2.
    start = 1'b1;
    entry = cyc + 1;
    q0.push_back('{entry + 8, 1, 1'b0});
    q0.push_back('{entry + 15, 2, 1'b1});
    @(negedge clk);
    start = 1'b0;
    chk("start_running", running, 1);
    chk("start_cell_nrst", cell_nrst, 1);
    chk("start_seed_sel", seed_sel, 0);
    for (int k = 0; k <= 8; k++) begin
      at_cyc(entry + k);
      chk("phase_seq", phase, (k == 0) ? 0 : ((k - 1) % 7) + 1);
    end
    at_cyc(entry + 10);
    chk("pause_phase", phase, 3);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    at_cyc(entry + 14);
    chk("pre_boundary_running", running, 1);
    at_cyc(entry + 15);
    chk("hold_cell_nrst", cell_nrst, 0);
    chk("hold_seed_sel", seed_sel, 1);
    chk("hold_phase", phase, 0);
    chk("hold_gen_count", gen_count, 2);
    at_cyc(entry + 20);

    // Single step from HOLD.
    step = 1'b1;
    entry = cyc + 1;
    q0.push_back('{entry + 8, 3, 1'b1});
    @(negedge clk);
    step = 1'b0;
    chk("step_running", running, 1);
    chk("step_seed_sel", seed_sel, 1);
    chk("step_phase", phase, 0);
    at_cyc(entry + 25);
    chk("step_still_holding", holding, 1);

    // Resume, then pause in the phase-7 cycle itself.
    resume = 1'b1;
    entry = cyc + 1;
    q0.push_back('{entry + 8, 4, 1'b0});
    q0.push_back('{entry + 15, 5, 1'b1});
    @(negedge clk);
    resume = 1'b0;
    at_cyc(entry + 14);
    chk("p7_phase", phase, 7);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    chk("p7_holding", holding, 1);
    at_cyc(entry + 20);

    // Stop at phase 5: IDLE next cycle, count held, no gen_done.
    resume = 1'b1;
    entry = cyc + 1;
    q0.push_back('{entry + 8, 6, 1'b0});
    @(negedge clk);
    resume = 1'b0;
    at_cyc(entry + 12);
    chk("stop_phase", phase, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_running", running, 0);
    chk("stop_holding", holding, 0);
    chk("stop_phase_idle", phase, 0);
    chk("stop_gen_count", gen_count, 6);
    chk("stop_seed_sel", seed_sel, 0);
    at_cyc(entry + 30);

    // Stop and start together in RUN: stop wins.
    start = 1'b1;
    entry = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_gen_count", gen_count, 0);
    at_cyc(entry + 3);
    chk("ss_phase", phase, 3);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    chk("ss_running", running, 0);
    chk("ss_phase_idle", phase, 0);
    at_cyc(entry + 20);
    chk("ss_still_idle", running, 0);

    // Asynchronous reset at phase 6 of generation 2, between clock edges.
    start = 1'b1;
    entry = cyc + 1;
    q0.push_back('{entry + 8, 1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    at_cyc(entry + 13);
    chk("arst_pre_phase", phase, 6);
    chk("arst_pre_count", gen_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_running", running, 0);
    chk("arst_cell_nrst", cell_nrst, 0);
    chk("arst_phase", phase, 0);
    chk("arst_gen_count", gen_count, 0);
    chk("arst_gen_done", gen_done, 0);
    chk("arst_holding", holding, 0);
    chk("arst_seed_sel", seed_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    at_cyc(cyc + 2);

    // MAX_GENS=4 instance: auto-hold after 4, resume runs one generation.
    start_l = 1'b1;
    entry = cyc + 1;
    q1.push_back('{entry + 8, 1, 1'b0});
    q1.push_back('{entry + 15, 2, 1'b0});
    q1.push_back('{entry + 22, 3, 1'b0});
    q1.push_back('{entry + 29, 4, 1'b1});
    @(negedge clk);
    start_l = 1'b0;
    at_cyc(entry + 28);
    chk("lim_pre_limit_hit", limit_hit_l, 0);
    at_cyc(entry + 29);
    chk("lim_limit_hit", limit_hit_l, 1);
    chk("lim_cell_nrst", cell_nrst_l, 0);
    at_cyc(entry + 32);
    resume_l = 1'b1;
    entry = cyc + 1;
    q1.push_back('{entry + 8, 5, 1'b1});
    @(negedge clk);
    resume_l = 1'b0;
    at_cyc(entry + 20);
    chk("lim_after_resume_holding", holding_l, 1);
    chk("lim_after_resume_count", gen_count_l, 5);
    chk("lim_after_resume_hit", limit_hit_l, 1);
    stop_l = 1'b1;
    @(negedge clk);
    stop_l = 1'b0;
    chk("lim_stop_clears_hit", limit_hit_l, 0);
    chk("lim_stop_holding", holding_l, 0);

    repeat (2) @(negedge clk);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation controller for a LifeCell array. It drives the array-wide synchronous cell reset and seed-source select, and tracks the cells' 8-phase evaluation cycle (phase 0 seed load, phases 1–7 neighbour accumulation and update). It flags each completed generation and counts generations. It accepts start, pause, single-step, resume and stop commands, so the grid can be frozen at a generation boundary and restarted without losing state.

## Interface
- GEN_W, 16: width of the generation counter.
- MAX_GENS, 0: automatic pause after this many generations. 0 means unlimited.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: load the external pattern and run. Honoured only in IDLE.
- pause  in  1  one-cycle pulse: freeze at the next generation boundary. Honoured only in RUN.
- step  in  1  one-cycle pulse: run exactly one generation, then freeze. Honoured only in HOLD.
- resume  in  1  one-cycle pulse: continue free-running. Honoured only in HOLD.
- stop  in  1  one-cycle pulse: abort immediately to IDLE. Honoured in any state.
- cell_nrst  out  1  active-low synchronous reset to every cell. Equals (state==RUN).
- seed_sel  out  1  seed mux select for the array: 0 = external pattern, 1 = each cell's own alive output.
- phase  out  3  mirror of the cell FSM state. 0 outside RUN.
- gen_done  out  1  one-cycle pulse; cell alive outputs hold the new generation in that cycle.
- gen_count  out  GEN_W  completed generations since the last start.
- running  out  1  state==RUN.
- holding  out  1  state==HOLD.
- limit_hit  out  1  sticky; set when MAX_GENS is reached. Cleared by start or stop.

## Operation
- All outputs are registered or decoded directly from registers. No input-to-output combinational path.
- States:
  - IDLE: cells held in reset; seed_sel=0.
  - RUN: cells evaluating.
  - HOLD: cells held in reset; seed_sel=1, so that re-entry reloads the frozen pattern.
- Command priority in one cycle: stop > start > pause > step > resume. Commands not legal in the current state are dropped, not queued.
- IDLE:
  - start: go to RUN with seed_sel=0, phase=0.
  - start also clears gen_count, limit_hit, pause_pend and step_pend.
- RUN, phase sequence: 0→1→2→…→7→1→… Phase 0 occurs only on entry, because the cell loads its seed in phase 0.
- RUN, boundary: the edge leaving phase 7 is the generation boundary. At that edge:
  - gen_done is set for the next cycle.
  - gen_count increments, saturating at all-ones.
- RUN, exit at the boundary: go to HOLD at the same edge if any of the following holds, otherwise stay in RUN at phase 1:
  - pause_pend is set;
  - step_pend is set;
  - pause is asserted in the phase-7 cycle itself;
  - MAX_GENS!=0 and the incremented count equals MAX_GENS. This also sets limit_hit.
- RUN, pending flags:
  - pause in phases 0–6 sets pause_pend.
  - pause_pend and step_pend clear on entry to HOLD.
- RUN, stop at any phase: go to IDLE next cycle and clear pause_pend and step_pend.
  - Cells retain the last completed generation, because alive is written only in phases 0 and 7.
  - gen_count holds its value; gen_done is not pulsed.
- HOLD:
  - step: go to RUN with step_pend=1, seed_sel=1, phase=0.
  - resume: go to RUN with seed_sel=1, phase=0.
  - If limit_hit is set, resume behaves like step.
- seed_sel is constant throughout RUN: the value chosen on entry. It is meaningful only at phase 0.

## Timing
- Reset values:
  - state=IDLE, cell_nrst=0, seed_sel=0, phase=0;
  - gen_done=0, gen_count=0, running=0, holding=0, limit_hit=0;
  - pause_pend=0, step_pend=0.
- Command sampled at edge N: state, cell_nrst and phase change after edge N.
- Seed load: the cell loads its seed at the edge where phase==0 and cell_nrst==1.
- Generation period: 7 cycles (phases 1–7). First gen_done comes 8 cycles after the RUN-entry edge.
- Leaving RUN at the boundary:
  - The cell sees cell_nrst=1 at the boundary edge and updates alive.
  - The cell is forced to state 0 one edge later.
  - alive is not reset, so the frozen pattern persists through HOLD and IDLE.
- gen_done and the HOLD transition are visible in the same cycle.
- rst asserted mid-generation: everything returns to reset values asynchronously. Cell alive contents are undefined to this block.

## Test plan
- Start with seed pattern: rst, then start pulse → phase sequence 0,1,…,7,1; gen_done at cycles 8, 15 and 22 after entry; gen_count 1, 2, 3.
- Pause mid-generation: pause at phase 3 of generation 2 → HOLD entered at the generation 2 boundary; gen_count=2; cell_nrst=0; seed_sel=1; blinker pattern shows generation-2 orientation.
- Step from HOLD: step → exactly one gen_done 8 cycles later; back to HOLD; gen_count=3; blinker orientation flipped.
- Limit: MAX_GENS=4, start → HOLD after the 4th gen_done; limit_hit=1; resume → one generation only; gen_count=5.
- Stop mid-generation: stop at phase 5 → IDLE next cycle; no gen_done; gen_count held. Stop and start in the same cycle while in RUN → IDLE (stop wins).
- Async reset: rst asserted at phase 6 without a clock edge → all outputs at reset values immediately. pause at phase 7 → HOLD at that boundary.
